cpu_bus_seq: RTL and testbench
==============================

CPU_BUS_SEQ -- requirements
Module: cpu_bus_seq

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum consecutive T3 wait states before forced completion (1..255).
REQ-002 clk  input  1  single clock; one rising edge = one T-cycle.
REQ-003 nreset  input  1  reset, synchronous, active-low.
REQ-004 adr  input  16  core address for next M-cycle; sampled on the edge entering T1.
REQ-005 dout  input  8  core write data; sampled with adr.
REQ-006 rd  input  1  core read request; sampled with adr.
REQ-007 wr  input  1  core write request; sampled with adr.
REQ-008 din  output  8  read data returned to core.
REQ-009 tphase  output  2  current T-state: 0=T1, 1=T2, 2=T3, 3=T4.
REQ-010 mcyc_start  output  1  high while tphase=T1.
REQ-011 mcyc_done  output  1  high while tphase=T4; core presents next request during this cycle.
REQ-012 ext_adr  output  16  external address bus.
REQ-013 ext_dout  output  8  external write data.
REQ-014 ext_oe  output  1  external data bus driven by this block.
REQ-015 ext_din  input  8  external read data.
REQ-016 ext_rd_n  output  1  external read strobe, active-low.
REQ-017 ext_wr_n  output  1  external write strobe, active-low.
REQ-018 ext_wait  input  1  external wait request, honoured only in T3.
REQ-019 proto_err  output  1  sticky error flag.

Function
REQ-020 Phase counter SHALL advance T1->T2->T3->T4->T1 on each edge, except for T3 hold per REQ-027.
REQ-021 Edge entering T1 SHALL latch adr/dout/rd/wr into request registers and load ext_adr from adr.
REQ-022 ext_adr SHALL hold the latched address through T1..T4, including no-mem cycles (rd=wr=0).
REQ-023 Read cycle: ext_rd_n low during T1, T2, T3 (including wait states); high in T4.
REQ-024 Write cycle: ext_wr_n low during T2 and T3 only; ext_oe high during T2, T3, T4; ext_dout = latched dout whenever ext_oe=1.
REQ-025 No-mem cycle: ext_rd_n=ext_wr_n=1, ext_oe=0, din unchanged.
REQ-026 Read data: the edge leaving T3 SHALL capture ext_din into din; din holds the value until the next read capture.
REQ-027 ext_wait=1 in T3 SHALL hold tphase at T3, with a wait counter incremented per held cycle.
REQ-028 Wait counter SHALL clear on T1 entry.
REQ-029 When the wait count reaches MAX_WAIT, the next edge SHALL advance to T4 regardless of ext_wait and set proto_err.
REQ-030 rd=wr=1 sampled together: write SHALL take precedence, rd ignored, proto_err set.
REQ-031 ext_wait in T1, T2 or T4 SHALL be ignored.
REQ-032 proto_err SHALL stay set until reset.
REQ-033 Latency: read data valid at din from the first T4 cycle, i.e. 3 edges after T1 entry plus wait states.

Reset
REQ-034 nreset=0 at an edge SHALL force the following outputs, aborting any cycle in progress: tphase=T4, mcyc_done=1, mcyc_start=0, ext_rd_n=1, ext_wr_n=1, ext_oe=0, ext_adr=0, ext_dout=0, din=0xFF, proto_err=0, wait counter=0, request registers cleared.
REQ-035 First edge with nreset=1 SHALL enter T1 and latch the request presented.

Verification
REQ-036 Read, no wait: adr=0xC000, rd=1, ext_din=0x5A -> ext_rd_n low T1..T3; din=0x5A at T4; ext_wr_n=1 and ext_oe=0 throughout.
REQ-037 Write: adr=0xFFFE, dout=0x12, wr=1 -> ext_adr=0xFFFE for T1..T4; ext_wr_n low T2..T3; ext_oe=1 and ext_dout=0x12 for T2..T4.
REQ-038 Back-to-back writes to 0xFFFE then 0xFFFD -> ext_adr changes only on T1 entry; no-mem cycle with adr=0xFFFD in between keeps all strobes high.
REQ-039 Wait: ext_wait=1 for 3 cycles in T3 -> T3 lasts 4 cycles; ext_din captured on the edge leaving T3; proto_err=0.
REQ-040 Wait cap: ext_wait stuck at 1 with MAX_WAIT=15 -> T4 after 15 wait cycles; proto_err=1 until reset.
REQ-041 Error and reset: rd=wr=1 -> write cycle and proto_err=1; nreset=0 during T2 of a write -> next cycle ext_wr_n=1, ext_oe=0, tphase=T4, proto_err=0.

Source files
------------

// File: rtl/cpu_bus_seq.sv
// T-state bus sequencer: turns core read/write requests into a four-phase
// (T1..T4) external bus cycle with T3 wait-state insertion and a wait time-out.
module cpu_bus_seq #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] adr,
    input  logic [7:0]  dout,
    input  logic        rd,
    input  logic        wr,
    output logic [7:0]  din,
    output logic [1:0]  tphase,
    output logic        mcyc_start,
    output logic        mcyc_done,
    output logic [15:0] ext_adr,
    output logic [7:0]  ext_dout,
    output logic        ext_oe,
    input  logic [7:0]  ext_din,
    output logic        ext_rd_n,
    output logic        ext_wr_n,
    input  logic        ext_wait,
    output logic        proto_err
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2,
        T4 = 2'd3
    } tstate_t;

    tstate_t     r_state;
    tstate_t     w_state_nxt;
    logic        w_hold;
    logic        w_wait_cap;
    logic [7:0]  r_wait_cnt;
    logic        r_rd;
    logic        r_wr;
    logic [15:0] r_adr;
    logic [7:0]  r_dout;
    logic [7:0]  r_din;
    logic        r_proto_err;

    always_comb begin
        w_state_nxt = r_state;
        w_hold      = 1'b0;
        w_wait_cap  = 1'b0;
        case (r_state)
            T1: w_state_nxt = T2;
            T2: w_state_nxt = T3;
            T3: begin
                // Time-out wins over a still-asserted wait request.
                if (r_wait_cnt >= LP_MAX_WAIT) begin
                    w_wait_cap  = 1'b1;
                    w_state_nxt = T4;
                end else if (ext_wait) begin
                    w_hold = 1'b1;
                end else begin
                    w_state_nxt = T4;
                end
            end
            default: w_state_nxt = T1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= T4;
            r_wait_cnt  <= 8'd0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_adr       <= 16'h0000;
            r_dout      <= 8'h00;
            r_din       <= 8'hFF;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == T4) begin
                // Write beats read when the core asks for both.
                r_rd       <= rd & ~wr;
                r_wr       <= wr;
                r_adr      <= adr;
                r_dout     <= dout;
                r_wait_cnt <= 8'd0;
                if (rd && wr) begin
                    r_proto_err <= 1'b1;
                end
            end
            if (w_hold) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_wait_cap) begin
                r_proto_err <= 1'b1;
            end
            if (r_state == T3 && w_state_nxt == T4 && r_rd) begin
                r_din <= ext_din;
            end
        end
    end

    assign tphase     = r_state;
    assign mcyc_start = (r_state == T1);
    assign mcyc_done  = (r_state == T4);
    assign ext_adr    = r_adr;
    assign ext_dout   = r_dout;
    assign ext_rd_n   = ~(r_rd && (r_state != T4));
    assign ext_wr_n   = ~(r_wr && (r_state == T2 || r_state == T3));
    assign ext_oe     = r_wr && (r_state != T1);
    assign din        = r_din;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Directed bench for cpu_bus_seq: a vector table for read/write/no-mem cycles
// plus hand-written wait-state, time-out and abort sequences.
module tb_cpu_bus_seq;

    logic        clk;
    logic        nreset;
    logic [15:0] adr;
    logic [7:0]  dout;
    logic        rd;
    logic        wr;
    logic [7:0]  din;
    logic [1:0]  tphase;
    logic        mcyc_start;
    logic        mcyc_done;
    logic [15:0] ext_adr;
    logic [7:0]  ext_dout;
    logic        ext_oe;
    logic [7:0]  ext_din;
    logic        ext_rd_n;
    logic        ext_wr_n;
    logic        ext_wait;
    logic        proto_err;

    int n_checks = 0;
    int n_errors = 0;

    cpu_bus_seq #(.MAX_WAIT(15)) dut (
        .clk(clk), .nreset(nreset), .adr(adr), .dout(dout), .rd(rd), .wr(wr),
        .din(din), .tphase(tphase), .mcyc_start(mcyc_start), .mcyc_done(mcyc_done),
        .ext_adr(ext_adr), .ext_dout(ext_dout), .ext_oe(ext_oe), .ext_din(ext_din),
        .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n), .ext_wait(ext_wait),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        nrst;
        logic [15:0] adr;
        logic [7:0]  dout;
        logic        rd;
        logic        wr;
        logic [7:0]  edin;
        logic        ewait;
        logic [1:0]  tp;
        logic [15:0] eadr;
        logic        rdn;
        logic        wrn;
        logic        oe;
        logic [7:0]  edout;
        logic [7:0]  din;
        logic        perr;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(logic nrst, logic [15:0] a, logic [7:0] d, logic r, logic w,
                                logic [7:0] ed, logic ew, logic [1:0] tp, logic [15:0] ea,
                                logic rdn, logic wrn, logic oe, logic [7:0] edo,
                                logic [7:0] di, logic pe);
        vec_t v;
        v.nrst = nrst; v.adr = a; v.dout = d; v.rd = r; v.wr = w; v.edin = ed; v.ewait = ew;
        v.tp = tp; v.eadr = ea; v.rdn = rdn; v.wrn = wrn; v.oe = oe; v.edout = edo;
        v.din = di; v.perr = pe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] tp, input logic [15:0] eadr,
                              input logic rdn, input logic wrn, input logic oe,
                              input logic [7:0] edout, input logic [7:0] di, input logic pe);
        chk({tag, ".tphase"}, 32'(tphase), 32'(tp));
        chk({tag, ".mcyc_start"}, 32'(mcyc_start), 32'(tp == 2'd0));
        chk({tag, ".mcyc_done"}, 32'(mcyc_done), 32'(tp == 2'd3));
        chk({tag, ".ext_adr"}, 32'(ext_adr), 32'(eadr));
        chk({tag, ".ext_rd_n"}, 32'(ext_rd_n), 32'(rdn));
        chk({tag, ".ext_wr_n"}, 32'(ext_wr_n), 32'(wrn));
        chk({tag, ".ext_oe"}, 32'(ext_oe), 32'(oe));
        if (oe) chk({tag, ".ext_dout"}, 32'(ext_dout), 32'(edout));
        chk({tag, ".din"}, 32'(din), 32'(di));
        chk({tag, ".proto_err"}, 32'(proto_err), 32'(pe));
    endtask

    initial begin
        int n_t3;
        nreset = 1'b0; adr = 16'h0; dout = 8'h0; rd = 1'b0; wr = 1'b0;
        ext_din = 8'h0; ext_wait = 1'b0;

        //          nrst adr      dout   rd wr edin   ew | tp eadr     rdn wrn oe edout din    perr
        vt[0]  = mk(0, 16'h0000, 8'h00, 0, 0, 8'h00, 0,   3, 16'h0000, 1,  1,  0, 8'h00, 8'hFF, 0);
        vt[1]  = mk(1, 16'hC000, 8'h00, 1, 0, 8'h00, 0,   0, 16'hC000, 0,  1,  0, 8'h00, 8'hFF, 0);
        vt[2]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h5A, 0,   1, 16'hC000, 0,  1,  0, 8'h00, 8'hFF, 0);
        vt[3]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h5A, 0,   2, 16'hC000, 0,  1,  0, 8'h00, 8'hFF, 0);
        vt[4]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h5A, 0,   3, 16'hC000, 1,  1,  0, 8'h00, 8'h5A, 0);
        vt[5]  = mk(1, 16'hFFFE, 8'h12, 0, 1, 8'h00, 0,   0, 16'hFFFE, 1,  1,  0, 8'h12, 8'h5A, 0);
        vt[6]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h00, 0,   1, 16'hFFFE, 1,  0,  1, 8'h12, 8'h5A, 0);
        vt[7]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h00, 0,   2, 16'hFFFE, 1,  0,  1, 8'h12, 8'h5A, 0);
        vt[8]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h00, 0,   3, 16'hFFFE, 1,  1,  1, 8'h12, 8'h5A, 0);
        vt[9]  = mk(1, 16'hFFFD, 8'h00, 0, 0, 8'h00, 0,   0, 16'hFFFD, 1,  1,  0, 8'h00, 8'h5A, 0);
        vt[10] = mk(1, 16'h1234, 8'h99, 0, 1, 8'h00, 0,   1, 16'hFFFD, 1,  1,  0, 8'h00, 8'h5A, 0);
        vt[11] = mk(1, 16'h1234, 8'h99, 0, 1, 8'h00, 1,   2, 16'hFFFD, 1,  1,  0, 8'h00, 8'h5A, 0);
        vt[12] = mk(1, 16'h0000, 8'h00, 0, 0, 8'h00, 0,   3, 16'hFFFD, 1,  1,  0, 8'h00, 8'h5A, 0);
        vt[13] = mk(1, 16'hFFFD, 8'h34, 0, 1, 8'h00, 1,   0, 16'hFFFD, 1,  1,  0, 8'h00, 8'h5A, 0);
        vt[14] = mk(1, 16'h0000, 8'h00, 0, 0, 8'h00, 1,   1, 16'hFFFD, 1,  0,  1, 8'h34, 8'h5A, 0);
        vt[15] = mk(1, 16'h0000, 8'h00, 0, 0, 8'h00, 0,   2, 16'hFFFD, 1,  0,  1, 8'h34, 8'h5A, 0);
        vt[16] = mk(1, 16'h0000, 8'h00, 0, 0, 8'h00, 0,   3, 16'hFFFD, 1,  1,  1, 8'h34, 8'h5A, 0);

        for (int i = 0; i < 17; i++) begin
            nreset = vt[i].nrst; adr = vt[i].adr; dout = vt[i].dout; rd = vt[i].rd;
            wr = vt[i].wr; ext_din = vt[i].edin; ext_wait = vt[i].ewait;
            tick();
            check_outs($sformatf("vec%0d", i), vt[i].tp, vt[i].eadr, vt[i].rdn, vt[i].wrn,
                       vt[i].oe, vt[i].edout, vt[i].din, vt[i].perr);
        end

        // Read with three wait states; data must be taken on the edge leaving T3.
        adr = 16'h0100; rd = 1'b1; wr = 1'b0; ext_din = 8'h11; ext_wait = 1'b0;
        tick(); check_outs("wait.t1", 0, 16'h0100, 0, 1, 0, 8'h00, 8'h5A, 0);
        adr = 16'h0000; rd = 1'b0;
        tick(); check_outs("wait.t2", 1, 16'h0100, 0, 1, 0, 8'h00, 8'h5A, 0);
        tick(); check_outs("wait.t3", 2, 16'h0100, 0, 1, 0, 8'h00, 8'h5A, 0);
        ext_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_outs($sformatf("wait.w%0d", i), 2, 16'h0100, 0, 1, 0, 8'h00, 8'h5A, 0);
        end
        ext_wait = 1'b0; ext_din = 8'hA7;
        tick(); check_outs("wait.t4", 3, 16'h0100, 1, 1, 0, 8'h00, 8'hA7, 0);

        // Stuck wait: T3 lasts 1 + 15 wait cycles, then forced T4 with error.
        adr = 16'h0200; rd = 1'b1; ext_din = 8'h3C;
        tick(); rd = 1'b0; adr = 16'h0000;
        tick(); tick();
        n_t3 = 1;
        ext_wait = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tphase == 2'd2) n_t3++;
            else break;
        end
        chk("cap.t3_cycles", 32'(n_t3), 32'd16);
        check_outs("cap.t4", 3, 16'h0200, 1, 1, 0, 8'h00, 8'h3C, 1);
        ext_wait = 1'b0;
        tick(); tick(); tick(); tick();
        chk("cap.sticky", 32'(proto_err), 32'd1);
        nreset = 1'b0;
        tick(); check_outs("cap.reset", 3, 16'h0000, 1, 1, 0, 8'h00, 8'hFF, 0);

        // rd and wr together: write cycle plus error, then abort by reset in T2.
        nreset = 1'b1; adr = 16'h2000; dout = 8'h55; rd = 1'b1; wr = 1'b1;
        tick(); check_outs("both.t1", 0, 16'h2000, 1, 1, 0, 8'h00, 8'hFF, 1);
        rd = 1'b0; wr = 1'b0; adr = 16'h0000; dout = 8'h00;
        tick(); check_outs("both.t2", 1, 16'h2000, 1, 0, 1, 8'h55, 8'hFF, 1);
        nreset = 1'b0;
        tick(); check_outs("abort", 3, 16'h0000, 1, 1, 0, 8'h00, 8'hFF, 0);
        nreset = 1'b1; adr = 16'h0042;
        tick(); check_outs("restart.t1", 0, 16'h0042, 1, 1, 0, 8'h00, 8'hFF, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
